seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 4-bit combinational ALU.
- Operations: multiply, subtract, AND, XOR on WIDTH-bit operands, with the same op encoding and Zero/Carry/Overflow/Sign flags.
- Multiply uses an iterative shift-add datapath (one partial product per cycle) instead of an array multiplier.
- Operands and results move over valid/ready handshakes; the block sits between the operand register/controller logic and the result display/register path of the FPGA controller.

Parameters:
- WIDTH, 4, operand width in bits; result is 2*WIDTH bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept a new operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sel  input  2  op: 00 MUL, 01 SUB, 10 AND, 11 XOR.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  2*WIDTH  operation result.
- Z  output  1  zero flag.
- C  output  1  carry/borrow flag.
- V  output  1  signed overflow flag.
- S  output  1  sign flag.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, Z=0, C=0, V=0, S=0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch A, B and sel.
  - sel=MUL goes to MUL with count=0 and accumulator=0.
  - Any other op computes the result and flags into output registers and goes to DONE.
- MUL:
  - in_ready=0.
  - Each cycle: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift multiplicand left and multiplier right; count++.
  - After exactly WIDTH cycles, register the product and flags and go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - result and flags are held stable until out_ready=1.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - No new operation is accepted in the same cycle as the output handshake.
- Latency (accept edge to out_valid rising): SUB/AND/XOR 1 cycle; MUL WIDTH+1 cycles. Minimum issue interval is 2 cycles (non-MUL) and WIDTH+2 cycles (MUL).
- Result widths:
  - MUL: full 2*WIDTH unsigned product.
  - SUB: (A-B) mod 2^WIDTH, zero-extended.
  - AND/XOR: bitwise, zero-extended.
- Flags:
  - Z = (2*WIDTH-bit result == 0), valid for all ops.
  - S = SUB ? diff[WIDTH-1] : 0.
  - C = SUB ? borrow (A < B unsigned) : 0.
  - V = SUB ? (A[W-1]&~B[W-1]&~diff[W-1]) | (~A[W-1]&B[W-1]&diff[W-1]) : 0.
- Input changes while not in IDLE are ignored; the latched operands are used.
- in_valid deasserted in IDLE: no state change; outputs hold their last values, out_valid=0.
- rst asserted in any state, including mid-MUL: abort, return to reset values next edge, discard any pending result.
- Multiply by 0 still takes the full WIDTH cycles (no early termination).

Optional Feature:
- Macro: SEQ_ALU_MUL_FLAGS_EN.
- Defined, for MUL:
  - V = (result[2W-1:W] != 0), i.e. the product does not fit in WIDTH bits.
  - C = V.
  - S stays 0.
- Undefined: C/V/S are 0 for MUL, as in the base definition.
- Z behaviour is identical with or without the macro.

Decomposition:
- Package alu_pkg holds:
  - enum alu_op_e {OP_MUL=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11}.
  - FSM state enum seq_alu_state_e {S_IDLE, S_MUL, S_DONE}.
  - localparam MAX_WIDTH=16.
- One sub-module, shift_add_mul:
  - Inputs: start, A, B.
  - Outputs: busy, done, P[2W-1:0].
  - Contains the iteration counter and accumulator.
  - The FSM and flag logic stay in seq_alu.

Test Plan (WIDTH=4):
- MUL A=F, B=F, out_ready=1 -> out_valid 5 cycles after accept; result=8'hE1; Z=0, C=0, V=0, S=0 (with the macro: V=1, C=1).
- SUB A=3, B=5 -> next cycle result=8'h0E; S=1, C=1, V=0, Z=0.
- SUB A=8, B=1 -> result=8'h07; V=1, S=0, C=0. SUB A=6, B=6 -> result=0, Z=1.
- AND A=A, B=5 -> result=0, Z=1; XOR A=A, B=5 -> result=8'h0F, Z=0.
- Backpressure: SUB completes with out_ready=0 for 3 cycles -> out_valid and result held stable, in_ready=0; A/B toggling during the hold has no effect; out_ready=1 -> IDLE next cycle.
- Reset mid-MUL: rst=1 on cycle 2 of MUL -> next edge all outputs 0, in_ready=1; no out_valid follows.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encoding, FSM states and width limits.
package alu_pkg;

  localparam int MAX_WIDTH = 16;
  localparam int CNT_W     = $clog2(MAX_WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } seq_alu_state_e;

endpackage

// File: rtl/seq_alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, exactly WIDTH cycles.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign busy       = r_busy;
  assign done       = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  // P carries the accumulator including this cycle's partial product, so it is the full product when done=1.
  assign P          = w_acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU (MUL/SUB/AND/XOR) with valid/ready handshakes and Z/C/V/S flags.
// Optional macro SEQ_ALU_MUL_FLAGS_EN: MUL reports C=V=(product does not fit in WIDTH bits).
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 Z,
  output logic                 C,
  output logic                 V,
  output logic                 S
);

  localparam int RW = 2 * WIDTH;

  seq_alu_state_e r_state, w_next;
  logic           w_start;
  logic           w_mul_busy;
  logic           w_mul_done;
  logic [RW-1:0]  w_prod;
  logic [RW-1:0]  r_result;
  logic           r_z, r_c, r_v, r_s;
  alu_op_e        w_op;

  assign w_op = alu_op_e'(sel);

  // Packed as {result, Z, C, V, S}.
  function automatic logic [RW+3:0] logic_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input alu_op_e op);
    logic [WIDTH-1:0] d;
    logic [RW-1:0]    r;
    logic             c, v, s;
    d = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    s = 1'b0;
    case (op)
      OP_SUB: begin
        d = a - b;
        r = {{WIDTH{1'b0}}, d};
        c = (a < b);
        s = d[WIDTH-1];
        v = (a[WIDTH-1] & ~b[WIDTH-1] & ~d[WIDTH-1]) |
            (~a[WIDTH-1] & b[WIDTH-1] & d[WIDTH-1]);
      end
      OP_AND:  r = {{WIDTH{1'b0}}, a & b};
      OP_XOR:  r = {{WIDTH{1'b0}}, a ^ b};
      default: r = '0;
    endcase
    return {r, (r == '0), c, v, s};
  endfunction

  function automatic logic [RW+3:0] mul_op(input logic [RW-1:0] p);
    logic ovf;
    ovf = 1'b0;
`ifdef SEQ_ALU_MUL_FLAGS_EN
    ovf = (p[RW-1:WIDTH] != '0);
`endif
    return {p, (p == '0), ovf, ovf, 1'b0};
  endfunction

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .A     (A),
    .B     (B),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .P     (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_op == OP_MUL) begin
            w_next  = S_MUL;
            w_start = 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (w_mul_done)       w_next = S_DONE;
        // Recovery only: the multiplier should never be idle while we wait on it.
        else if (!w_mul_busy) w_next = S_IDLE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_result, r_z, r_c, r_v, r_s} <= '0;
    end else if (r_state == S_IDLE && in_valid && w_op != OP_MUL) begin
      {r_result, r_z, r_c, r_v, r_s} <= logic_op(A, B, w_op);
    end else if (r_state == S_MUL && w_mul_done) begin
      {r_result, r_z, r_c, r_v, r_s} <= mul_op(w_prod);
    end
  end

  assign result = r_result;
  assign Z      = r_z;
  assign C      = r_c;
  assign V      = r_v;
  assign S      = r_s;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed and random ops against an arithmetic reference model.
module tb_seq_alu;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [1:0]    sel = '0;
  logic          in_ready, out_valid, Z, C, V, S;
  logic [RW-1:0] result;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Z(Z), .C(C), .V(V), .S(S)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          z, c, v, s;
    logic          mul;
    logic [31:0]   acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  bit          stall = 0;
  bit          rnd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    int   ia, ib, diff, sa, sb, sd, prod;
    e  = '0;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'b00: begin
        prod  = ia * ib;
        e.res = RW'(prod);
        e.mul = 1'b1;
`ifdef SEQ_ALU_MUL_FLAGS_EN
        e.v = (prod >= (1 << W));
        e.c = e.v;
`endif
      end
      2'b01: begin
        diff  = ((ia - ib) + (1 << W)) % (1 << W);
        e.res = RW'(diff);
        e.c   = (ia < ib);
        e.s   = (diff >= (1 << (W - 1)));
        sa    = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
        sb    = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
        sd    = sa - sb;
        e.v   = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
      end
      2'b10:   e.res = RW'(ia & ib);
      default: e.res = RW'(ia ^ ib);
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Consumer ready changes just after the rising edge, so it is stable at every sample point.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Issue one op; caller is at a falling edge. Expected response is queued as it is issued.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    exp_t e;
    int   n = 0;
    while (!(in_ready && !rst)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: in_ready stayed %0b, required 1", in_ready);
        return;
      end
    end
    A = a; B = b; sel = op; in_valid = 1'b1;
    e = model(a, b, op);
    e.acc = cyc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    sel = 2'($urandom);
  endtask

  // Monitor: latency on out_valid rise, stability while stalled, value check on handshake.
  initial begin
    logic            prev_ov = 1'b0;
    logic            holding = 1'b0;
    logic [RW+3:0]   hold_val = '0;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
        holding = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got out_valid=1 with nothing outstanding, required 0");
          end else begin
            chk("latency", cyc - q[0].acc, q[0].mul ? 32'(W + 1) : 32'd1);
          end
        end
        if (out_valid && holding)
          chk("hold_stable", 32'({result, Z, C, V, S}), 32'(hold_val));
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("flags_ZCVS", {28'd0, Z, C, V, S}, {28'd0, e.z, e.c, e.v, e.s});
          holding = 1'b0;
        end else if (out_valid) begin
          holding  = 1'b1;
          hold_val = {result, Z, C, V, S};
        end else begin
          holding = 1'b0;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {28'd0, Z, C, V, S}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(4'hF, 4'hF, 2'b00);
    issue(4'h3, 4'h5, 2'b01);
    issue(4'h8, 4'h1, 2'b01);
    issue(4'h6, 4'h6, 2'b01);
    issue(4'hA, 4'h5, 2'b10);
    issue(4'hA, 4'h5, 2'b11);
    issue(4'h0, 4'h7, 2'b00);
    issue(4'h7, 4'h8, 2'b01);
    drain();

    rnd = 1;
    for (int i = 0; i < 60; i++)
      issue(W'($urandom), W'($urandom), 2'($urandom));
    drain();
    rnd = 0;

    // Backpressure: result must hold while A/B wiggle, then release.
    stall = 1;
    @(negedge clk);
    issue(4'h3, 4'h5, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'h0E);
      A = ~A;
      B = ~B;
      @(negedge clk);
    end
    stall = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Abort a multiply in its second cycle.
    issue(4'h7, 4'h9, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", {28'd0, Z, C, V, S}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", 32'(seen), 32'd0);

    issue(4'h2, 4'h3, 2'b00);
    issue(4'hC, 4'h9, 2'b01);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
